// File: rtl/z80_pin_pkg.sv
// Shared definitions for the Z80 pin multiplexer: frame phase encoding, control strobe bit
// positions and the packed control type.
package z80_pin_pkg;

  // Frame phases; the phase counter walks these in order and wraps.
  localparam logic [1:0] PH_ADDR_LO = 2'd0;
  localparam logic [1:0] PH_ADDR_HI = 2'd1;
  localparam logic [1:0] PH_CTRL    = 2'd2;
  localparam logic [1:0] PH_DATA    = 2'd3;

  typedef enum logic [1:0] {
    PhAddrLo = PH_ADDR_LO,
    PhAddrHi = PH_ADDR_HI,
    PhCtrl   = PH_CTRL,
    PhData   = PH_DATA
  } z80_phase_e;

  // Bit positions of the active-low strobes inside the control byte.
  localparam int unsigned CTRL_M1    = 7;
  localparam int unsigned CTRL_MREQ  = 6;
  localparam int unsigned CTRL_IORQ  = 5;
  localparam int unsigned CTRL_RD    = 4;
  localparam int unsigned CTRL_WR    = 3;
  localparam int unsigned CTRL_RFSH  = 2;
  localparam int unsigned CTRL_HALT  = 1;
  localparam int unsigned CTRL_BUSAK = 0;

  typedef logic [7:0] z80_ctrl_t;

endpackage

// File: rtl/z80_pin_mux_if.sv
// Core-side bus and pad-side pins of the Z80 pin multiplexer.
// master: the core/pad environment; slave: the multiplexer itself.
interface z80_pin_mux_if;
  import z80_pin_pkg::*;

  logic [15:0] cpu_addr;
  z80_ctrl_t   cpu_ctrl;
  logic [7:0]  cpu_dout;
  logic        cpu_doe;
  logic [7:0]  cpu_din;
  logic        cpu_ce;
  logic [7:0]  uo_out;
  logic [7:0]  uio_in;
  logic [7:0]  uio_out;
  logic [7:0]  uio_oe;
  logic [1:0]  phase;

  modport master (
    output cpu_addr, cpu_ctrl, cpu_dout, cpu_doe, uio_in,
    input  cpu_din, cpu_ce, uo_out, uio_out, uio_oe, phase
  );

  modport slave (
    input  cpu_addr, cpu_ctrl, cpu_dout, cpu_doe, uio_in,
    output cpu_din, cpu_ce, uo_out, uio_out, uio_oe, phase
  );

endinterface

// File: rtl/z80_pin_mux.sv
// Z80 pin multiplexer: runs a 4-phase frame that presents a snapshot of the core's address,
// control strobes and write data on the tt pads, and pulses cpu_ce once per frame.
// Optional feature macro: Z80_MUX_HOLD_EN adds a 'hold' input that stretches phase 3 (WAIT).
module z80_pin_mux
  import z80_pin_pkg::*;
#(
  parameter int unsigned             CTRL_W     = 8,
  parameter logic [CTRL_W-1:0]       RESET_CTRL = 8'hFF
) (
  input  logic           clk,
  input  logic           reset,
`ifdef Z80_MUX_HOLD_EN
  input  logic           hold,
`endif
  z80_pin_mux_if.slave   bus
);

  z80_phase_e        ph_q, ph_d;
  logic [15:0]       addr_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [7:0]        dout_q;
  logic              doe_q;
  logic [7:0]        din_q;
  logic              ce_q, ce_d;
  logic              advance;
  logic              hold_in;

`ifdef Z80_MUX_HOLD_EN
  assign hold_in = hold;
`else
  assign hold_in = 1'b0;
`endif

  // Phase counter next state: wraps 3->0 unless held in the data phase.
  always_comb begin
    advance = (ph_q == PhData) && !hold_in;
    ph_d    = ph_q;
    ce_d    = 1'b0;
    unique case (ph_q)
      PhAddrLo: ph_d = PhAddrHi;
      PhAddrHi: ph_d = PhCtrl;
      PhCtrl:   ph_d = PhData;
      PhData:   ph_d = advance ? PhAddrLo : PhData;
      default:  ph_d = PhAddrLo;
    endcase
    ce_d = (ph_d == PhData);
  end

  // Phase register, snapshot of the pre-advance core state, and read data capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      ph_q   <= PhAddrLo;
      addr_q <= 16'h0000;
      ctrl_q <= RESET_CTRL;
      dout_q <= 8'h00;
      doe_q  <= 1'b0;
      din_q  <= 8'h00;
      ce_q   <= 1'b0;
    end else begin
      ph_q <= ph_d;
      ce_q <= ce_d;
      if (advance) begin
        addr_q <= bus.cpu_addr;
        ctrl_q <= bus.cpu_ctrl;
        dout_q <= bus.cpu_dout;
        doe_q  <= bus.cpu_doe;
      end
      if (ph_q == PhCtrl && !doe_q) begin
        din_q <= bus.uio_in;
      end
    end
  end

  // Pad mux from registered sources; data pins only drive in phases 2/3 so the bus can turn.
  always_comb begin
    bus.uo_out = 8'h00;
    unique case (ph_q)
      PhAddrLo: bus.uo_out = addr_q[7:0];
      PhAddrHi: bus.uo_out = addr_q[15:8];
      PhCtrl:   bus.uo_out = ctrl_q;
      PhData:   bus.uo_out = ctrl_q;
      default:  bus.uo_out = 8'h00;
    endcase
    bus.uio_out = dout_q;
    bus.uio_oe  = ((ph_q == PhCtrl) || (ph_q == PhData)) ? {8{doe_q}} : 8'h00;
    bus.cpu_din = din_q;
    // A held data phase must not let the core advance.
    bus.cpu_ce  = ce_q && !hold_in;
    bus.phase   = ph_q;
  end

endmodule
